// File: rtl/ppc_fuse_pkg.sv
// Opcode constants and field helpers shared by the update-form instruction fuser.
package ppc_fuse_pkg;

    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_LBZ  = 6'd34;
    localparam logic [5:0] OP_LHZ  = 6'd40;
    localparam logic [5:0] OP_STW  = 6'd36;
    localparam logic [5:0] OP_STB  = 6'd38;
    localparam logic [5:0] OP_STH  = 6'd44;
    localparam logic [5:0] OP_ADDI = 6'd14;

    function automatic logic [5:0] insn_opcd(input logic [31:0] insn);
        return insn[31:26];
    endfunction

    function automatic logic [4:0] insn_rt(input logic [31:0] insn);
        return insn[25:21];
    endfunction

    function automatic logic [4:0] insn_ra(input logic [31:0] insn);
        return insn[20:16];
    endfunction

    function automatic logic [15:0] insn_d(input logic [31:0] insn);
        return insn[15:0];
    endfunction

    // A load that overwrites its own base cannot be folded into an update form.
    function automatic logic is_fuse_candidate(input logic [31:0] insn);
        logic [5:0] op;
        logic       is_load;
        logic       is_store;
        op       = insn_opcd(insn);
        is_load  = (op == OP_LWZ) || (op == OP_LBZ) || (op == OP_LHZ);
        is_store = (op == OP_STW) || (op == OP_STB) || (op == OP_STH);
        return (insn_ra(insn) != 5'd0) &&
               (is_store || (is_load && (insn_rt(insn) != insn_ra(insn))));
    endfunction

    function automatic logic [31:0] to_update_form(input logic [31:0] insn);
        return {insn_opcd(insn) + 6'd1, insn[25:0]};
    endfunction

endpackage

// File: rtl/fuse_match.sv
// Decides whether the incoming instruction is the base-update addi of the held access.
module fuse_match
    import ppc_fuse_pkg::*;
(
    input  logic [31:0] hold_insn,
    input  logic [31:0] hold_pc,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    output logic        match,
    output logic        in_candidate,
    output logic [31:0] fused_insn
);

    assign match = (insn_opcd(in_insn) == OP_ADDI) &&
                   (insn_rt(in_insn) == insn_ra(hold_insn)) &&
                   (insn_ra(in_insn) == insn_ra(hold_insn)) &&
                   (insn_d(in_insn) == insn_d(hold_insn)) &&
                   (in_pc == hold_pc + 32'd4);

    assign in_candidate = is_fuse_candidate(in_insn);
    assign fused_insn   = to_update_form(hold_insn);

endmodule

// File: rtl/insn_fuser.sv
// Recombines a D-form load/store and its following base-register addi into the
// update-form instruction, using a one-entry hold buffer and a registered output.
module insn_fuser
    import ppc_fuse_pkg::*;
#(
    parameter int unsigned HOLD_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic        out_fused,
    input  logic        out_ready
);

    localparam int unsigned    CntW    = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [CntW-1:0] IdleMax = CntW'(HOLD_TIMEOUT - 1);

    typedef enum logic {StEmpty, StHold} state_e;

    state_e          state_q;
    logic [31:0]     hold_insn_q;
    logic [31:0]     hold_pc_q;
    logic [CntW-1:0] idle_cnt_q;
    logic            out_valid_q;
    logic [31:0]     out_insn_q;
    logic [31:0]     out_pc_q;
    logic            out_fused_q;

    logic            match;
    logic            in_candidate;
    logic [31:0]     fused_insn;
    logic            hold_v;
    logic            out_free;
    logic            accept;

    fuse_match u_fuse_match (
        .hold_insn    (hold_insn_q),
        .hold_pc      (hold_pc_q),
        .in_insn      (in_insn),
        .in_pc        (in_pc),
        .match        (match),
        .in_candidate (in_candidate),
        .fused_insn   (fused_insn)
    );

    assign hold_v   = (state_q == StHold);
    assign out_free = ~out_valid_q | out_ready;
    // A held access blocks a non-matching, non-candidate input for one cycle while it drains.
    assign in_ready = ~rst & out_free & ~flush & ~(hold_v & in_valid & ~match & ~in_candidate);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            hold_insn_q <= '0;
            hold_pc_q   <= '0;
            idle_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_pc_q    <= '0;
            out_fused_q <= 1'b0;
        end else if (flush) begin
            state_q     <= StEmpty;
            idle_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StEmpty: begin
                    idle_cnt_q <= '0;
                    if (accept) begin
                        if (in_candidate) begin
                            hold_insn_q <= in_insn;
                            hold_pc_q   <= in_pc;
                            state_q     <= StHold;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_insn_q  <= in_insn;
                            out_pc_q    <= in_pc;
                            out_fused_q <= 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (accept) begin
                        idle_cnt_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_pc_q    <= hold_pc_q;
                        if (match) begin
                            out_insn_q  <= fused_insn;
                            out_fused_q <= 1'b1;
                            state_q     <= StEmpty;
                        end else begin
                            out_insn_q  <= hold_insn_q;
                            out_fused_q <= 1'b0;
                            hold_insn_q <= in_insn;
                            hold_pc_q   <= in_pc;
                        end
                    end else if (in_valid) begin
                        idle_cnt_q <= '0;
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_insn_q  <= hold_insn_q;
                            out_pc_q    <= hold_pc_q;
                            out_fused_q <= 1'b0;
                            state_q     <= StEmpty;
                        end
                    end else if (idle_cnt_q == IdleMax) begin
                        // Counter saturates here until the output register frees up.
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_insn_q  <= hold_insn_q;
                            out_pc_q    <= hold_pc_q;
                            out_fused_q <= 1'b0;
                            state_q     <= StEmpty;
                            idle_cnt_q  <= '0;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_insn  = out_insn_q;
    assign out_pc    = out_pc_q;
    assign out_fused = out_fused_q;

endmodule

// File: tb/tb_insn_fuser.sv
// Directed scenarios plus a randomized stream checked against a stream-level fusion model.
module tb_insn_fuser;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        out_fused;
    logic        out_ready;

    always #5 clk = ~clk;

    insn_fuser #(.HOLD_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_insn  (out_insn),
        .out_pc    (out_pc),
        .out_fused (out_fused),
        .out_ready (out_ready)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    bit          rand_ready = 0;
    logic [64:0] got_q[$];
    logic [31:0] acc_insn_q[$];
    logic [31:0] acc_pc_q[$];

    // Output transfers, recorded as {fused, pc, insn}.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back({out_fused, out_pc, out_insn});
    end

    function automatic logic [64:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one instruction until accepted (bounded); returns just after the accepting edge.
    task automatic send(input logic [31:0] insn, input logic [31:0] pc);
        bit acc = 0;
        in_valid = 1'b1;
        in_insn  = insn;
        in_pc    = pc;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (!acc) begin
            tests_failed++;
            $display("FAIL send_accept: insn %h pc %h got in_ready 0 for 50 cycles, required 1",
                     insn, pc);
        end else begin
            acc_insn_q.push_back(insn);
            acc_pc_q.push_back(pc);
        end
    endtask

    // Reference rules expressed with plain arithmetic on the instruction word.
    function automatic bit m_cand(input logic [31:0] w);
        int unsigned op = w >> 26;
        int unsigned rt = (w >> 21) & 31;
        int unsigned ra = (w >> 16) & 31;
        bit ld = (op == 32) || (op == 34) || (op == 40);
        bit st = (op == 36) || (op == 38) || (op == 44);
        return (ra != 0) && (st || (ld && rt != ra));
    endfunction

    function automatic bit m_match(input logic [31:0] h, input logic [31:0] hp,
                                   input logic [31:0] w, input logic [31:0] p);
        logic [31:0] nxt = hp + 32'd4;
        return ((w >> 26) == 14) && (((w >> 21) & 31) == ((h >> 16) & 31)) &&
               (((w >> 16) & 31) == ((h >> 16) & 31)) && ((w & 32'hFFFF) == (h & 32'hFFFF)) &&
               (p == nxt);
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_insn = 32'h3863_0008; in_pc = 32'h0;
        out_ready = 1'b1;
        idle(2);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        tests_run++;
        if ({out_valid, out_fused, out_pc, out_insn} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v%b f%b pc %h insn %h, required all zero",
                     out_valid, out_fused, out_pc, out_insn);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_in_ready: got %b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_fused_pair();
        got_q.delete();
        out_ready = 1'b1;
        send(32'h9123_0008, 32'h100);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fused_hold_no_out: got out_valid %b, required 0", out_valid);
        end
        send(32'h3863_0008, 32'h104);
        tests_run++;
        if ({out_valid, out_fused, out_pc, out_insn} !== {1'b1, 1'b1, 32'h100, 32'h9523_0008}) begin
            tests_failed++;
            $display("FAIL fused_out: got v%b f%b pc %h insn %h, required v1 f1 pc 100 insn 95230008",
                     out_valid, out_fused, out_pc, out_insn);
        end
        idle(2);
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL fused_count: got %0d outputs, required 1", got_q.size());
        end
    endtask

    task automatic test_load_ra_rt();
        got_q.delete();
        out_ready = 1'b1;
        send(32'h8063_0004, 32'h200);
        send(32'h3863_0004, 32'h204);
        idle(2);
        tests_run++;
        if (got_q.size() != 2) begin
            tests_failed++;
            $display("FAIL ldrt_count: got %0d outputs, required 2", got_q.size());
        end
        tests_run++;
        if (got_at(0) !== {1'b0, 32'h200, 32'h8063_0004}) begin
            tests_failed++;
            $display("FAIL ldrt_first: got %h, required %h", got_at(0),
                     {1'b0, 32'h200, 32'h8063_0004});
        end
        tests_run++;
        if (got_at(1) !== {1'b0, 32'h204, 32'h3863_0004}) begin
            tests_failed++;
            $display("FAIL ldrt_second: got %h, required %h", got_at(1),
                     {1'b0, 32'h204, 32'h3863_0004});
        end
    endtask

    task automatic test_disp_mismatch();
        got_q.delete();
        out_ready = 1'b1;
        send(32'h9123_0008, 32'h100);
        send(32'h3863_0004, 32'h104);
        idle(2);
        tests_run++;
        if (got_at(0) !== {1'b0, 32'h100, 32'h9123_0008} ||
            got_at(1) !== {1'b0, 32'h104, 32'h3863_0004} || got_q.size() != 2) begin
            tests_failed++;
            $display("FAIL disp_order: got %0d outputs [%h %h], required [%h %h]", got_q.size(),
                     got_at(0), got_at(1), {1'b0, 32'h100, 32'h9123_0008},
                     {1'b0, 32'h104, 32'h3863_0004});
        end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        out_ready = 1'b1;
        send(32'h9123_0008, 32'h100);
        out_ready = 1'b0;
        send(32'h3863_0008, 32'h104);
        in_valid = 1'b1; in_insn = 32'h6000_0000; in_pc = 32'h108;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({out_valid, out_fused, out_pc, out_insn, in_ready} !==
                {1'b1, 1'b1, 32'h100, 32'h9523_0008, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: got v%b f%b pc %h insn %h rdy %b, required v1 f1 pc 100 insn 95230008 rdy 0",
                         k, out_valid, out_fused, out_pc, out_insn, in_ready);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (got_q.size() != 1 || got_at(0) !== {1'b1, 32'h100, 32'h9523_0008} ||
            out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: got %0d outputs first %h valid %b, required 1 output %h valid 0",
                     got_q.size(), got_at(0), out_valid, {1'b1, 32'h100, 32'h9523_0008});
        end
    endtask

    task automatic test_timeout();
        got_q.delete();
        out_ready = 1'b1;
        send(32'h9924_0001, 32'h300);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            tests_run++;
            if (out_valid !== (k == 4)) begin
                tests_failed++;
                $display("FAIL timeout_cycle%0d: got out_valid %b, required %b", k, out_valid, k == 4);
            end
        end
        tests_run++;
        if ({out_fused, out_pc, out_insn} !== {1'b0, 32'h300, 32'h9924_0001}) begin
            tests_failed++;
            $display("FAIL timeout_data: got f%b pc %h insn %h, required f0 pc 300 insn 99240001",
                     out_fused, out_pc, out_insn);
        end
        idle(2);
    endtask

    task automatic test_flush_reset(input bit use_rst);
        got_q.delete();
        out_ready = 1'b1;
        send(32'h9123_0008, 32'h100);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        in_valid = 1'b1; in_insn = 32'h3863_0008; in_pc = 32'h104;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_in_ready(rst=%0d): got %b, required 0", use_rst, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        send(32'h3863_0008, 32'h104);
        idle(6);
        tests_run++;
        if (got_q.size() != 1 || got_at(0) !== {1'b0, 32'h104, 32'h3863_0008}) begin
            tests_failed++;
            $display("FAIL drop_hold(rst=%0d): got %0d outputs first %h, required 1 output %h",
                     use_rst, got_q.size(), got_at(0), {1'b0, 32'h104, 32'h3863_0008});
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [6] = '{6'd32, 6'd34, 6'd40, 6'd36, 6'd38, 6'd44};
        logic [64:0] exp_q[$];
        logic [31:0] pc = 32'hFFFF_FF00;
        logic [31:0] prev = 32'h0;
        logic [31:0] w;
        logic [31:0] ph = 32'h0;
        logic [31:0] pp = 32'h0;
        bit          pend = 0;
        int          k;
        got_q.delete();
        acc_insn_q.delete();
        acc_pc_q.delete();
        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 99);
            if (m_cand(prev) && k < 50) begin
                w = {6'd14, prev[20:16], prev[20:16], prev[15:0]};
                if (k < 8) w[2] = ~w[2];
            end else if (k < 75) begin
                w = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     16'(4 * $urandom_range(0, 2))};
            end else if (k < 90) begin
                w = {6'd14, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     16'(4 * $urandom_range(0, 2))};
            end else begin
                w = $urandom;
            end
            pc = pc + (($urandom_range(0, 9) == 0) ? 32'd8 : 32'd4);
            send(w, pc);
            prev = w;
            idle($urandom_range(0, 2));
        end
        rand_ready = 0;
        out_ready = 1'b1;
        idle(12);
        for (int i = 0; i < acc_insn_q.size(); i++) begin
            w = acc_insn_q[i];
            if (pend && m_match(ph, pp, w, acc_pc_q[i])) begin
                exp_q.push_back({1'b1, pp, ph + 32'h0400_0000});
                pend = 0;
            end else begin
                if (pend) exp_q.push_back({1'b0, pp, ph});
                pend = 0;
                if (m_cand(w)) begin
                    pend = 1; ph = w; pp = acc_pc_q[i];
                end else begin
                    exp_q.push_back({1'b0, acc_pc_q[i], w});
                end
            end
        end
        if (pend) exp_q.push_back({1'b0, pp, ph});
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (got_at(i) !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_out%0d: got %h, required %h", i, got_at(i), exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fused_pair();
        test_load_ra_rt();
        test_disp_mismatch();
        test_backpressure();
        test_timeout();
        test_flush_reset(1'b0);
        test_flush_reset(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
